// File: rtl/bids22_ctrl_seq.sv
// ---------------------------------------------------------------------------
// bids22_ctrl_seq
// Controller-side initiator for the bids22 auction block's C_op/C_data/C_start
// port. A single cfg_go pulse snapshots the configuration and issues, one op
// per two cycles (issue + error check), the sequence
//   Unlock, LoadX, LoadY, LoadZ, SetXYZmask, SetTimer, BidCharge, Lock
// then holds C_start high for max(cfg_round,1) cycles and waits for ready.
// The winning bid and winner flags are captured on ready. Any non-zero err
// after an op, or a ready timeout, aborts with a Lock op and a fail pulse.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   cfg_go                start strobe (ignored while busy / during done)
//   cfg_*                 sequence configuration, sampled on the go cycle
//   C_op, C_data, C_start command interface to the auction block
//   err, ready, maxBid,
//   X_win, Y_win, Z_win   status/results from the auction block
//   busy, done, fail      sequence status (done/fail are 1-cycle pulses)
//   fail_err, fail_step   err value and opcode of the abort (4'hF = timeout)
//   res_max, res_win      captured maxBid and {Z_win,Y_win,X_win}
// ---------------------------------------------------------------------------
module bids22_ctrl_seq #(
  parameter logic [31:0] UNLOCK_KEY    = 32'h0F0F_0F0F,
  parameter int unsigned READY_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_go,
  input  logic [31:0] cfg_x_value,
  input  logic [31:0] cfg_y_value,
  input  logic [31:0] cfg_z_value,
  input  logic [2:0]  cfg_mask,
  input  logic [31:0] cfg_timer,
  input  logic [31:0] cfg_charge,
  input  logic [15:0] cfg_round,
  output logic [3:0]  C_op,
  output logic [31:0] C_data,
  output logic        C_start,
  input  logic [1:0]  err,
  input  logic        ready,
  input  logic [31:0] maxBid,
  input  logic        X_win,
  input  logic        Y_win,
  input  logic        Z_win,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [1:0]  fail_err,
  output logic [3:0]  fail_step,
  output logic [31:0] res_max,
  output logic [2:0]  res_win
);

  localparam logic [3:0] OP_NOOP    = 4'd0;
  localparam logic [3:0] OP_UNLOCK  = 4'd1;
  localparam logic [3:0] OP_LOCK    = 4'd2;
  localparam logic [3:0] OP_LOADX   = 4'd3;
  localparam logic [3:0] OP_LOADY   = 4'd4;
  localparam logic [3:0] OP_LOADZ   = 4'd5;
  localparam logic [3:0] OP_MASK    = 4'd6;
  localparam logic [3:0] OP_TIMER   = 4'd7;
  localparam logic [3:0] OP_CHARGE  = 4'd8;
  localparam logic [3:0] STEP_TMO   = 4'hF;
  localparam logic [2:0] LAST_STEP  = 3'd7;
  localparam logic [31:0] TMO_LAST  = 32'(READY_TIMEOUT - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_RUN,
    S_WAIT_RDY,
    S_ABORT
  } state_t;

  // Opcode issued at each step of the configuration sequence.
  function automatic logic [3:0] step_op(input logic [2:0] s);
    case (s)
      3'd0:    step_op = OP_UNLOCK;
      3'd1:    step_op = OP_LOADX;
      3'd2:    step_op = OP_LOADY;
      3'd3:    step_op = OP_LOADZ;
      3'd4:    step_op = OP_MASK;
      3'd5:    step_op = OP_TIMER;
      3'd6:    step_op = OP_CHARGE;
      default: step_op = OP_LOCK;
    endcase
  endfunction

  // Operand paired with each step; Lock carries zero.
  function automatic logic [31:0] step_data(
    input logic [2:0]  s,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z,
    input logic [2:0]  m,
    input logic [31:0] t,
    input logic [31:0] c
  );
    case (s)
      3'd0:    step_data = UNLOCK_KEY;
      3'd1:    step_data = x;
      3'd2:    step_data = y;
      3'd3:    step_data = z;
      3'd4:    step_data = {29'b0, m};
      3'd5:    step_data = t;
      3'd6:    step_data = c;
      default: step_data = 32'd0;
    endcase
  endfunction

  // A programmed round length of zero still opens the round for one cycle.
  function automatic logic [15:0] round_len(input logic [15:0] r);
    round_len = (r == 16'd0) ? 16'd1 : r;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic [31:0] tcnt_q, tcnt_d;

  logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d, timer_q, timer_d, charge_q, charge_d;
  logic [2:0]  mask_q, mask_d;
  logic [15:0] round_q, round_d;

  logic [3:0]  c_op_q, c_op_d;
  logic [31:0] c_data_q, c_data_d;
  logic        c_start_q, c_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic [1:0]  fail_err_q, fail_err_d;
  logic [3:0]  fail_step_q, fail_step_d;
  logic [31:0] res_max_q, res_max_d;
  logic [2:0]  res_win_q, res_win_d;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    rcnt_d      = rcnt_q;
    tcnt_d      = tcnt_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    charge_d    = charge_q;
    round_d     = round_q;
    fail_err_d  = fail_err_q;
    fail_step_d = fail_step_q;
    res_max_d   = res_max_q;
    res_win_d   = res_win_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    c_op_d      = OP_NOOP;
    c_data_d    = 32'd0;
    c_start_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // done_q marks the cycle right after completion; a go there is dropped.
        if (cfg_go && !done_q) begin
          x_d      = cfg_x_value;
          y_d      = cfg_y_value;
          z_d      = cfg_z_value;
          mask_d   = cfg_mask;
          timer_d  = cfg_timer;
          charge_d = cfg_charge;
          round_d  = cfg_round;
          step_d   = 3'd0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: begin
        if (err != 2'd0) begin
          fail_err_d  = err;
          fail_step_d = step_op(step_q);
          state_d     = S_ABORT;
        end else if (step_q != LAST_STEP) begin
          step_d  = 3'(step_q + 3'd1);
          state_d = S_ISSUE;
        end else begin
          rcnt_d  = round_len(round_q);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rcnt_q == 16'd1) begin
          tcnt_d  = 32'd0;
          state_d = S_WAIT_RDY;
        end else begin
          rcnt_d = 16'(rcnt_q - 16'd1);
        end
      end
      S_WAIT_RDY: begin
        // ready takes priority over an expiring timeout in the same cycle.
        if (ready) begin
          res_max_d = maxBid;
          res_win_d = {Z_win, Y_win, X_win};
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else if (tcnt_q == TMO_LAST) begin
          fail_err_d  = 2'd0;
          fail_step_d = STEP_TMO;
          state_d     = S_ABORT;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      S_ISSUE: begin
        c_op_d   = step_op(step_d);
        c_data_d = step_data(step_d, x_d, y_d, z_d, mask_d, timer_d, charge_d);
      end
      S_RUN:   c_start_d = 1'b1;
      S_ABORT: begin
        c_op_d = OP_LOCK;
        fail_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      rcnt_q      <= 16'd0;
      tcnt_q      <= 32'd0;
      c_op_q      <= OP_NOOP;
      c_data_q    <= 32'd0;
      c_start_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_err_q  <= 2'd0;
      fail_step_q <= 4'd0;
      res_max_q   <= 32'd0;
      res_win_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      c_op_q      <= c_op_d;
      c_data_q    <= c_data_d;
      c_start_q   <= c_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_err_q  <= fail_err_d;
      fail_step_q <= fail_step_d;
      res_max_q   <= res_max_d;
      res_win_q   <= res_win_d;
    end
  end

  // Configuration snapshot: only meaningful after a go, so no reset needed.
  always_ff @(posedge clk) begin
    x_q      <= x_d;
    y_q      <= y_d;
    z_q      <= z_d;
    mask_q   <= mask_d;
    timer_q  <= timer_d;
    charge_q <= charge_d;
    round_q  <= round_d;
  end

  assign C_op      = c_op_q;
  assign C_data    = c_data_q;
  assign C_start   = c_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_err  = fail_err_q;
  assign fail_step = fail_step_q;
  assign res_max   = res_max_q;
  assign res_win   = res_win_q;

endmodule

// File: tb/tb_bids22_ctrl_seq.sv
module tb_bids22_ctrl_seq;

  localparam logic [31:0] KEY = 32'h0F0F_0F0F;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_go;
  logic [31:0] cfg_x_value, cfg_y_value, cfg_z_value, cfg_timer, cfg_charge;
  logic [2:0]  cfg_mask;
  logic [15:0] cfg_round;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic [1:0]  err;
  logic        ready;
  logic [31:0] maxBid;
  logic        X_win, Y_win, Z_win;
  logic        busy, done, fail;
  logic [1:0]  fail_err;
  logic [3:0]  fail_step;
  logic [31:0] res_max;
  logic [2:0]  res_win;

  int checks = 0;
  int failures = 0;

  bids22_ctrl_seq #(.UNLOCK_KEY(KEY), .READY_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_go(cfg_go),
    .cfg_x_value(cfg_x_value), .cfg_y_value(cfg_y_value), .cfg_z_value(cfg_z_value),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_charge(cfg_charge),
    .cfg_round(cfg_round), .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .err(err), .ready(ready), .maxBid(maxBid), .X_win(X_win), .Y_win(Y_win),
    .Z_win(Z_win), .busy(busy), .done(done), .fail(fail), .fail_err(fail_err),
    .fail_step(fail_step), .res_max(res_max), .res_win(res_win)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        go;
    logic        rdy;
    logic [3:0]  op;
    logic [31:0] data;
    logic        start;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic g, input logic r, input logic [3:0] o,
                              input logic [31:0] d, input logic s, input logic b,
                              input logic dn);
    vec_t v;
    v.go = g; v.rdy = r; v.op = o; v.data = d; v.start = s; v.busy = b; v.done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_nominal();
    cfg_x_value = 32'd100; cfg_y_value = 32'd200; cfg_z_value = 32'd300;
    cfg_mask = 3'b111; cfg_timer = 32'd50; cfg_charge = 32'd1; cfg_round = 16'd4;
    maxBid = 32'd42; X_win = 1'b0; Y_win = 1'b1; Z_win = 1'b0;
    err = 2'd0; ready = 1'b0; cfg_go = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cfg_go = 1'b0; ready = 1'b0; err = 2'd0;
    end
  endtask

  // Row i drives cycle i's inputs and checks cycle i's registered outputs.
  task automatic run_table(input string tag);
    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      cfg_go = tbl[i].go; ready = tbl[i].rdy; err = 2'd0;
      @(negedge clk);
      chk($sformatf("%s op c%0d", tag, i), {28'd0, C_op}, {28'd0, tbl[i].op});
      chk($sformatf("%s data c%0d", tag, i), C_data, tbl[i].data);
      chk($sformatf("%s start c%0d", tag, i), {31'd0, C_start}, {31'd0, tbl[i].start});
      chk($sformatf("%s busy c%0d", tag, i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("%s done c%0d", tag, i), {31'd0, done}, {31'd0, tbl[i].done});
      chk($sformatf("%s fail c%0d", tag, i), {31'd0, fail}, 32'd0);
    end
    chk({tag, " res_max"}, res_max, 32'd42);
    chk({tag, " res_win"}, {29'd0, res_win}, 32'd2);
  endtask

  initial begin
    int n_op5, n_unlock, n_start, c17, c18;
    bit seen_end;

    tbl[0]  = mk(1, 0, 4'd0, 32'd0,   0, 0, 0);
    tbl[1]  = mk(0, 0, 4'd1, KEY,     0, 1, 0);
    tbl[2]  = mk(0, 0, 4'd0, 32'd0,   0, 1, 0);
    tbl[3]  = mk(0, 0, 4'd3, 32'd100, 0, 1, 0);
    tbl[4]  = mk(0, 0, 4'd0, 32'd0,   0, 1, 0);
    tbl[5]  = mk(0, 0, 4'd4, 32'd200, 0, 1, 0);
    tbl[6]  = mk(0, 0, 4'd0, 32'd0,   0, 1, 0);
    tbl[7]  = mk(0, 0, 4'd5, 32'd300, 0, 1, 0);
    tbl[8]  = mk(0, 0, 4'd0, 32'd0,   0, 1, 0);
    tbl[9]  = mk(0, 0, 4'd6, 32'd7,   0, 1, 0);
    tbl[10] = mk(0, 0, 4'd0, 32'd0,   0, 1, 0);
    tbl[11] = mk(0, 0, 4'd7, 32'd50,  0, 1, 0);
    tbl[12] = mk(0, 0, 4'd0, 32'd0,   0, 1, 0);
    tbl[13] = mk(0, 0, 4'd8, 32'd1,   0, 1, 0);
    tbl[14] = mk(0, 0, 4'd0, 32'd0,   0, 1, 0);
    tbl[15] = mk(0, 0, 4'd2, 32'd0,   0, 1, 0);
    tbl[16] = mk(0, 0, 4'd0, 32'd0,   0, 1, 0);
    tbl[17] = mk(0, 0, 4'd0, 32'd0,   1, 1, 0);
    tbl[18] = mk(0, 0, 4'd0, 32'd0,   1, 1, 0);
    tbl[19] = mk(0, 0, 4'd0, 32'd0,   1, 1, 0);
    tbl[20] = mk(0, 0, 4'd0, 32'd0,   1, 1, 0);
    tbl[21] = mk(0, 1, 4'd0, 32'd0,   0, 1, 0);
    tbl[22] = mk(0, 0, 4'd0, 32'd0,   0, 0, 1);

    set_nominal();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst C_op", {28'd0, C_op}, 32'd0);
    chk("rst C_data", C_data, 32'd0);
    chk("rst C_start", {31'd0, C_start}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst fail", {31'd0, fail}, 32'd0);
    chk("rst fail_err", {30'd0, fail_err}, 32'd0);
    chk("rst fail_step", {28'd0, fail_step}, 32'd0);
    chk("rst res_max", res_max, 32'd0);
    chk("rst res_win", {29'd0, res_win}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    idle(2);

    // Nominal sequence
    run_table("nom");
    idle(3);

    // Error after LoadY: CHECK of LoadY is cycle 6, abort cycle 7
    n_op5 = 0;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      cfg_go = (c == 0); err = (c == 6) ? 2'b01 : 2'b00; ready = 1'b0;
      @(negedge clk);
      if (C_op == 4'd5) n_op5++;
      if (c == 6) chk("err fail before abort", {31'd0, fail}, 32'd0);
      if (c == 7) begin
        chk("err abort op", {28'd0, C_op}, 32'd2);
        chk("err abort data", C_data, 32'd0);
        chk("err abort start", {31'd0, C_start}, 32'd0);
        chk("err fail", {31'd0, fail}, 32'd1);
        chk("err fail_err", {30'd0, fail_err}, 32'd1);
        chk("err fail_step", {28'd0, fail_step}, 32'd4);
        chk("err busy in abort", {31'd0, busy}, 32'd1);
      end
      if (c == 8) begin
        chk("err busy after", {31'd0, busy}, 32'd0);
        chk("err fail pulse width", {31'd0, fail}, 32'd0);
        chk("err op after", {28'd0, C_op}, 32'd0);
      end
    end
    chk("err no LoadZ", n_op5, 0);
    chk("err res_max kept", res_max, 32'd42);
    idle(3);

    // Ready timeout: WAIT_RDY cycles 21..28, abort in cycle 29
    maxBid = 32'd99;
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk); #1;
      cfg_go = (c == 0); err = 2'd0; ready = 1'b0;
      @(negedge clk);
      if (c == 28) begin
        chk("tmo fail early", {31'd0, fail}, 32'd0);
        chk("tmo busy waiting", {31'd0, busy}, 32'd1);
      end
      if (c == 29) begin
        chk("tmo fail", {31'd0, fail}, 32'd1);
        chk("tmo fail_step", {28'd0, fail_step}, 32'hF);
        chk("tmo fail_err", {30'd0, fail_err}, 32'd0);
        chk("tmo abort op", {28'd0, C_op}, 32'd2);
        chk("tmo res_max kept", res_max, 32'd42);
        chk("tmo res_win kept", {29'd0, res_win}, 32'd2);
      end
      if (c == 30) chk("tmo busy after", {31'd0, busy}, 32'd0);
    end
    maxBid = 32'd42;
    idle(3);

    // go pulses while busy and cfg change after go
    n_unlock = 0;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk); #1;
      cfg_go = (c == 0) || (c == 3) || (c == 10) || (c == 22);
      if (c == 2) cfg_x_value = 32'd999;
      ready = (c == 21); err = 2'd0;
      @(negedge clk);
      if (C_op == 4'd1) n_unlock++;
      if (c == 3) chk("busy LoadX data", C_data, 32'd100);
      if (c == 22) chk("busy done", {31'd0, done}, 32'd1);
      if (c == 23) chk("busy go on done ignored", {31'd0, busy}, 32'd0);
    end
    chk("busy single sequence", n_unlock, 1);
    cfg_x_value = 32'd100;
    idle(3);

    // Reset during RUN (cycle 18)
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk); #1;
      cfg_go = (c == 0); ready = 1'b0; err = 2'd0;
      reset_n = (c == 18) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 18) chk("rstrun start before", {31'd0, C_start}, 32'd1);
      if (c == 19) begin
        chk("rstrun C_start", {31'd0, C_start}, 32'd0);
        chk("rstrun C_op", {28'd0, C_op}, 32'd0);
        chk("rstrun busy", {31'd0, busy}, 32'd0);
      end
      if (c >= 19) begin
        if (done !== 1'b0 || fail !== 1'b0 || busy !== 1'b0)
          chk($sformatf("rstrun quiet c%0d", c), {29'd0, done, fail, busy}, 32'd0);
      end
    end
    run_table("rerun");
    idle(3);

    // round=0 -> exactly one C_start cycle (cycle 17)
    cfg_round = 16'd0;
    n_start = 0; seen_end = 0; c17 = 0; c18 = 0;
    for (int c = 0; c <= 100 && !seen_end; c++) begin
      @(posedge clk); #1;
      cfg_go = (c == 0); ready = 1'b0; err = 2'd0;
      @(negedge clk);
      if (C_start) n_start++;
      if (c == 17) c17 = int'(C_start);
      if (c == 18) c18 = int'(C_start);
      if (fail || done) seen_end = 1;
    end
    chk("r0 sequence ended", int'(seen_end), 1);
    chk("r0 start count", n_start, 1);
    chk("r0 start c17", c17, 1);
    chk("r0 start c18", c18, 0);
    idle(3);

    // round=16'hFFFF -> 65535 C_start cycles
    cfg_round = 16'hFFFF;
    n_start = 0; seen_end = 0;
    for (int c = 0; c <= 66000 && !seen_end; c++) begin
      @(posedge clk); #1;
      cfg_go = (c == 0); ready = 1'b0; err = 2'd0;
      @(negedge clk);
      if (C_start) n_start++;
      if (fail || done) seen_end = 1;
    end
    chk("rmax sequence ended", int'(seen_end), 1);
    chk("rmax start count", n_start, 65535);
    cfg_round = 16'd4;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
